wb_arb2: RTL and testbench
==========================

# wb_arb2

Two-master round-robin arbiter for the 8-bit Wishbone-style slave bus. It sits between two bus masters and one shared slave (the memory-backed `wb_slv`). It grants one transaction at a time, forwards the winner's cycle to the slave, and returns `ack`/`rdata` to that master only. A per-transaction timeout returns an error pulse and frees the bus if the slave never acknowledges.

## Interface
- `TIMEOUT`, 16: cycles in GRANT without `s_ack` before abort; legal range 2..255.
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `m0_stb`, `m1_stb` input 1: master request; held until that master's `ack` or `err`.
- `m0_we`, `m1_we` input 1: 1 = write, 0 = read; stable while `stb` is high.
- `m0_addr`, `m1_addr` input 8: address.
- `m0_wdata`, `m1_wdata` input 8: write data.
- `m0_rdata`, `m1_rdata` output 8: read data, registered, held between reads.
- `m0_ack`, `m1_ack` output 1: one-cycle completion pulse.
- `m0_err`, `m1_err` output 1: one-cycle timeout pulse.
- `s_stb`, `s_we` output 1: to slave, registered.
- `s_addr`, `s_wdata` output 8: to slave, registered.
- `s_rdata` input 8: from slave.
- `s_ack` input 1: slave completion pulse.
- `gnt` output 2: one-hot current grant; `01` = m0, `10` = m1, `00` = none.

## Operation
- States: IDLE, GRANT, DONE.
- IDLE:
  - If neither `stb` is high: stay.
  - If exactly one `stb` is high: grant it.
  - If both are high: grant the master that was not `last`.
  - On grant: latch the winner's `we`/`addr`/`wdata` into `s_we`/`s_addr`/`s_wdata`; set `s_stb`=1, `gnt`, `last`=winner; clear the timeout counter; go to GRANT.
- GRANT:
  - The counter increments each cycle.
  - If `s_ack`=1:
    - `s_stb`<=0.
    - Granted `mX_ack`<=1.
    - If `s_we`=0, granted `mX_rdata`<=`s_rdata`; the other master's `rdata` is unchanged.
    - Go to DONE.
  - Else if counter == `TIMEOUT`-1: `s_stb`<=0, granted `mX_err`<=1, go to DONE.
  - `s_ack` takes priority over timeout in the same cycle.
- DONE: one cycle.
  - `ack`/`err` return to 0; `gnt`<=`00`; go to IDLE.
  - This cycle guarantees `s_stb` is low for at least two cycles between transactions, so the slave never re-samples a stale request.
  - It also lets the master drop `stb` before re-arbitration.
- Requests are sampled only in IDLE.
- A master dropping `stb` during GRANT does not abort the cycle; the transaction completes normally.
- `s_ack` seen outside GRANT is ignored; no `ack` is forwarded.
- `last` resets to m1, so m0 wins the first tie.
- A lone requester is granted every time it requests, regardless of `last`.

## Timing
- Reset values: `s_stb`=0, `s_we`=0, `s_addr`=0, `s_wdata`=0, all `ack`/`err`=0, `m0_rdata`=`m1_rdata`=0, `gnt`=`00`, state IDLE, counter 0, `last`=m1.
- Reset mid-transaction drops `s_stb` at the next edge; no `ack` or `err` is issued.
- `stb` high at edge E in IDLE: `s_stb`/`gnt` are valid after E (1-cycle grant latency).
- `s_ack` high at edge F: `mX_ack`/`mX_rdata` are valid after F, and `s_stb` is low after F.
- IDLE is re-entered after F+1. Earliest next `s_stb` is after F+2.
- With `wb_slv`, `ack` arrives 3-4 cycles after `s_stb` rises, depending on slave phase.
- Timeout: `err` is valid after edge grant+`TIMEOUT`.
- Per-master throughput with `wb_slv` is at most one transaction per 6 cycles.
- Under continuous contention, grants alternate m0, m1, m0, … with no starvation.

## Test plan
- **Single write:** m0 writes `addr`=0x10, `wdata`=0xA5 to `wb_slv` → one `m0_ack` pulse, `m1_ack` stays 0, `gnt`=`01` during the cycle. A following m0 read of 0x10 → `m0_rdata`=0xA5.
- **Contention:** both masters hold `stb` after reset, m0 writing 0x01→0x11 and m1 writing 0x02→0x22 → grant order m0, m1. Readback gives 0x11 and 0x22; each master gets exactly one `ack`.
- **Continuous contention:** both re-request immediately after every `ack` for 6 transactions → `gnt` sequence 01, 10, 01, 10, 01, 10.
- **Lone requester:** m1 performs 3 back-to-back reads → all 3 granted to m1. `m0_rdata` stays unchanged.
- **Timeout:** slave stub holds `s_ack`=0, `TIMEOUT`=16, m0 requests → `m0_err` pulses exactly 16 cycles after grant, no `m0_ack`, `s_stb` low afterward. A subsequent m1 request is granted.
- **Reset mid-transaction:** assert `rst` 1 cycle into GRANT → `s_stb`=0, `gnt`=`00`, no `ack`/`err` after the edge. After release, a simultaneous request is granted to m0.

Source files
------------

// File: rtl/wb_arb2.sv
// Two-master round-robin arbiter for the 8-bit Wishbone-style slave bus.
// Grant is one cycle after the request; DONE holds s_stb low so the slave never sees a back-to-back strobe.
module wb_arb2 #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,

  input  logic       m0_stb,
  input  logic       m0_we,
  input  logic [7:0] m0_addr,
  input  logic [7:0] m0_wdata,
  output logic [7:0] m0_rdata,
  output logic       m0_ack,
  output logic       m0_err,

  input  logic       m1_stb,
  input  logic       m1_we,
  input  logic [7:0] m1_addr,
  input  logic [7:0] m1_wdata,
  output logic [7:0] m1_rdata,
  output logic       m1_ack,
  output logic       m1_err,

  output logic       s_stb,
  output logic       s_we,
  output logic [7:0] s_addr,
  output logic [7:0] s_wdata,
  input  logic [7:0] s_rdata,
  input  logic       s_ack,

  output logic [1:0] gnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       last_q, last_d;      // 1 = m1 won the most recent arbitration
  logic [1:0] gnt_q, gnt_d;

  logic       s_stb_q, s_stb_d;
  logic       s_we_q, s_we_d;
  logic [7:0] s_addr_q, s_addr_d;
  logic [7:0] s_wdata_q, s_wdata_d;

  logic [7:0] m0_rdata_q, m0_rdata_d;
  logic [7:0] m1_rdata_q, m1_rdata_d;
  logic       m0_ack_q, m0_ack_d;
  logic       m1_ack_q, m1_ack_d;
  logic       m0_err_q, m0_err_d;
  logic       m1_err_q, m1_err_d;

  logic       any_req;
  logic       win;                 // 1 = m1 wins this arbitration

  always_comb begin
    any_req = m0_stb | m1_stb;
    // On a tie the master that did not win last time goes next.
    if (m0_stb && m1_stb) begin
      win = ~last_q;
    end else begin
      win = m1_stb;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    s_stb_d    = s_stb_q;
    s_we_d     = s_we_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_err_d   = 1'b0;
    m1_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          s_stb_d   = 1'b1;
          s_we_d    = win ? m1_we    : m0_we;
          s_addr_d  = win ? m1_addr  : m0_addr;
          s_wdata_d = win ? m1_wdata : m0_wdata;
          gnt_d     = win ? 2'b10    : 2'b01;
          last_d    = win;
          cnt_d     = 8'd0;
          state_d   = ST_GRANT;
        end
      end

      ST_GRANT: begin
        cnt_d = cnt_q + 8'd1;
        // A slave ack in the same cycle as the timeout wins.
        if (s_ack) begin
          s_stb_d = 1'b0;
          state_d = ST_DONE;
          if (gnt_q[1]) begin
            m1_ack_d = 1'b1;
            if (!s_we_q) m1_rdata_d = s_rdata;
          end else begin
            m0_ack_d = 1'b1;
            if (!s_we_q) m0_rdata_d = s_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          s_stb_d = 1'b0;
          state_d = ST_DONE;
          if (gnt_q[1]) m1_err_d = 1'b1;
          else          m0_err_d = 1'b1;
        end
      end

      ST_DONE: begin
        gnt_d   = 2'b00;
        state_d = ST_IDLE;
      end

      default: begin
        s_stb_d = 1'b0;
        gnt_d   = 2'b00;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      last_q     <= 1'b1;
      gnt_q      <= 2'b00;
      s_stb_q    <= 1'b0;
      s_we_q     <= 1'b0;
      s_addr_q   <= 8'd0;
      s_wdata_q  <= 8'd0;
      m0_rdata_q <= 8'd0;
      m1_rdata_q <= 8'd0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      s_stb_q    <= s_stb_d;
      s_we_q     <= s_we_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_err_q   <= m0_err_d;
      m1_err_q   <= m1_err_d;
    end
  end

  assign s_stb    = s_stb_q;
  assign s_we     = s_we_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign gnt      = gnt_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign m0_ack   = m0_ack_q;
  assign m1_ack   = m1_ack_q;
  assign m0_err   = m0_err_q;
  assign m1_err   = m1_err_q;

endmodule

// File: tb/tb_wb_arb2.sv
// Bench for wb_arb2: behavioural slave with random ack delay, transaction-level
// arbitration/memory model, directed scenarios followed by random traffic.
module tb_wb_arb2;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m0_stb = 1'b0, m0_we = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
  logic [7:0] m0_addr = 8'd0, m0_wdata = 8'd0, m1_addr = 8'd0, m1_wdata = 8'd0;
  logic [7:0] m0_rdata, m1_rdata;
  logic       m0_ack, m1_ack, m0_err, m1_err;
  logic       s_stb, s_we;
  logic [7:0] s_addr, s_wdata;
  logic [7:0] s_rdata;
  logic       s_ack;
  logic [1:0] gnt;

  wb_arb2 #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack), .gnt(gnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } txn_t;

  // Slave: memory with random 0..2 cycle ack delay, optional hang, optional stray ack.
  logic [7:0] smem [256];
  logic       hang = 1'b0;
  int         delivered = 0;
  int         spur_cnt = 0;

  initial begin
    int   wcnt;
    int   dly;
    int   spur_done;
    logic spur;
    wcnt = 0; dly = 0; spur_done = 0; spur = 1'b0;
    s_ack = 1'b0; s_rdata = 8'd0;
    for (int i = 0; i < 256; i++) smem[i] = 8'(i) ^ 8'h5A;
    forever begin
      @(posedge clk); #2;
      if (s_ack) begin
        s_ack = 1'b0;
        if (!spur) delivered++;
        spur = 1'b0; wcnt = 0; dly = $urandom_range(0, 2);
      end else if (spur_cnt != spur_done) begin
        spur_done++; spur = 1'b1; s_ack = 1'b1; s_rdata = 8'hEE;
      end else if (s_stb && !hang) begin
        if (wcnt >= dly) begin
          s_ack = 1'b1;
          if (s_we) smem[s_addr] = s_wdata;
          else      s_rdata = smem[s_addr];
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Reference model: bus phase, round-robin memory, expected memory and read data.
  localparam int M_IDLE = 0, M_NEW = 1, M_BUSY = 2, M_DONE = 3;
  int         errors = 0, checks = 0;
  int         ms, owner, last_m, age, seen_dlv;
  int         gap [2];
  int         ack_cnt [2];
  int         err_cnt [2];
  txn_t       cur [2];
  logic [7:0] ref_mem [256];
  logic [7:0] rd_exp [2];
  int         glog [$];
  txn_t       q0 [$];
  txn_t       q1 [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int m);
    return (m == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic txn_t mk(input logic we, input logic [7:0] a, input logic [7:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    return mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
  endfunction

  task automatic drive_m(input int m, input logic stb, input txn_t t);
    if (m == 0) begin
      m0_stb = stb; m0_we = t.we; m0_addr = t.addr; m0_wdata = t.wdata;
    end else begin
      m1_stb = stb; m1_we = t.we; m1_addr = t.addr; m1_wdata = t.wdata;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_m(0, 1'b0, mk(1'b0, 8'd0, 8'd0));
    drive_m(1, 1'b0, mk(1'b0, 8'd0, 8'd0));
    repeat (2) @(negedge clk);
    chk("rst_s_stb", s_stb, 0);
    chk("rst_s_bus", {s_we, s_addr, s_wdata}, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_pulses", {m0_ack, m1_ack, m0_err, m1_err}, 0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
    rst = 1'b0;
    ms = M_IDLE; last_m = 1; rd_exp[0] = 8'd0; rd_exp[1] = 8'd0;
  endtask

  task automatic run_traffic(input int gmax, input int budget);
    bit   fin;
    bit   ackn;
    bit   errn;
    logic own_ack, own_err, oth;
    logic stbm;
    fin = 1'b0;
    glog.delete();
    for (int m = 0; m < 2; m++) begin gap[m] = 0; ack_cnt[m] = 0; err_cnt[m] = 0; end
    for (int n = 0; n < budget && !fin; n++) begin
      @(negedge clk);
      case (ms)
        M_NEW: begin
          chk("gnt_new", gnt, onehot(owner));
          chk("s_stb_new", s_stb, 1);
          chk("s_req", {s_we, s_addr, s_wdata}, cur[owner]);
          chk("pulses_new", {m0_ack, m1_ack, m0_err, m1_err}, 0);
          ms = M_BUSY; age = 0; seen_dlv = delivered;
        end
        M_BUSY: begin
          age++;
          ackn = (delivered != seen_dlv);
          seen_dlv = delivered;
          errn = !ackn && (age == TO);
          own_ack = (owner == 0) ? m0_ack : m1_ack;
          own_err = (owner == 0) ? m0_err : m1_err;
          oth     = (owner == 0) ? (m1_ack | m1_err) : (m0_ack | m0_err);
          chk("ack_owner", own_ack, ackn);
          chk("err_owner", own_err, errn);
          chk("other_quiet", oth, 0);
          chk("gnt_busy", gnt, onehot(owner));
          if (ackn || errn) begin
            chk("s_stb_drop", s_stb, 0);
            if (ackn) begin
              ack_cnt[owner]++;
              if (cur[owner].we) ref_mem[cur[owner].addr] = cur[owner].wdata;
              else               rd_exp[owner] = ref_mem[cur[owner].addr];
            end else begin
              err_cnt[owner]++;
            end
            chk("m0_rdata", m0_rdata, rd_exp[0]);
            chk("m1_rdata", m1_rdata, rd_exp[1]);
            drive_m(owner, 1'b0, cur[owner]);
            gap[owner] = $urandom_range(0, gmax);
            ms = M_DONE;
          end else begin
            chk("s_stb_hold", s_stb, 1);
          end
        end
        M_DONE: begin
          chk("gnt_done", gnt, 0);
          chk("s_stb_done", s_stb, 0);
          chk("pulses_done", {m0_ack, m1_ack, m0_err, m1_err}, 0);
          ms = M_IDLE;
        end
        default: begin
          chk("gnt_idle", gnt, 0);
          chk("s_stb_idle", s_stb, 0);
          chk("pulses_idle", {m0_ack, m1_ack, m0_err, m1_err}, 0);
        end
      endcase
      for (int m = 0; m < 2; m++) begin
        stbm = (m == 0) ? m0_stb : m1_stb;
        if (!stbm && ((m == 0) ? q0.size() : q1.size()) != 0) begin
          if (gap[m] == 0) begin
            if (m == 0) cur[0] = q0.pop_front();
            else        cur[1] = q1.pop_front();
            drive_m(m, 1'b1, cur[m]);
          end else begin
            gap[m]--;
          end
        end
      end
      if (ms == M_IDLE) begin
        if (m0_stb || m1_stb) begin
          if (m0_stb && m1_stb) owner = (last_m == 0) ? 1 : 0;
          else                  owner = m0_stb ? 0 : 1;
          last_m = owner;
          glog.push_back(owner);
          ms = M_NEW;
        end else if (q0.size() == 0 && q1.size() == 0) begin
          fin = 1'b1;
        end
      end
    end
    chk("traffic_done", fin, 1);
  endtask

  initial begin
    logic [7:0] r0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    do_reset();

    // Contention straight out of reset: m0 first, then m1.
    q0.push_back(mk(1'b1, 8'h01, 8'h11));
    q1.push_back(mk(1'b1, 8'h02, 8'h22));
    run_traffic(0, 200);
    chk("cont_size", glog.size(), 2);
    chk("cont_first", glog[0], 0);
    chk("cont_second", glog[1], 1);
    chk("cont_acks", {ack_cnt[0], ack_cnt[1]}, {32'd1, 32'd1});
    q0.push_back(mk(1'b0, 8'h01, 8'h00));
    q1.push_back(mk(1'b0, 8'h02, 8'h00));
    run_traffic(0, 200);
    chk("cont_rd0", m0_rdata, 8'h11);
    chk("cont_rd1", m1_rdata, 8'h22);

    // Single write then readback on m0.
    q0.push_back(mk(1'b1, 8'h10, 8'hA5));
    q0.push_back(mk(1'b0, 8'h10, 8'h00));
    run_traffic(2, 200);
    chk("single_acks", {ack_cnt[0], ack_cnt[1]}, {32'd2, 32'd0});
    chk("single_rd", m0_rdata, 8'hA5);
    chk("single_gnt", {glog.size(), glog[0], glog[1]}, {32'd2, 32'd0, 32'd0});

    // Continuous contention from reset alternates 01,10,...
    do_reset();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(rnd_txn());
      q1.push_back(rnd_txn());
    end
    run_traffic(0, 300);
    chk("alt_size", glog.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("alt_%0d", i), glog[i], i % 2);

    // Lone requester: m1 back-to-back reads, m0 data untouched.
    r0 = m0_rdata;
    for (int i = 0; i < 3; i++) q1.push_back(mk(1'b0, 8'(i + 3), 8'h00));
    run_traffic(0, 200);
    chk("lone_size", glog.size(), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("lone_%0d", i), glog[i], 1);
    chk("lone_m0_rdata", m0_rdata, r0);

    // Stray slave ack while idle is not forwarded.
    spur_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stray_pulses", {m0_ack, m1_ack, m0_err, m1_err}, 0);
      chk("stray_gnt", gnt, 0);
    end

    // Timeout on a hung slave, then m1 still served.
    hang = 1'b1;
    q0.push_back(mk(1'b0, 8'h20, 8'h00));
    run_traffic(0, 200);
    chk("to_counts", {ack_cnt[0], err_cnt[0]}, {32'd0, 32'd1});
    hang = 1'b0;
    q1.push_back(mk(1'b1, 8'h21, 8'h77));
    run_traffic(0, 200);
    chk("to_next_gnt", {glog.size(), glog[0]}, {32'd1, 32'd1});

    // Reset one cycle into GRANT.
    hang = 1'b1;
    cur[0] = mk(1'b1, 8'h30, 8'h99);
    drive_m(0, 1'b1, cur[0]);
    @(negedge clk);
    chk("mid_gnt", gnt, 2'b01);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_s_stb", s_stb, 0);
    chk("mid_gnt_clr", gnt, 0);
    chk("mid_pulses", {m0_ack, m1_ack, m0_err, m1_err}, 0);
    rst = 1'b0;
    hang = 1'b0;
    rd_exp[0] = 8'd0; rd_exp[1] = 8'd0;
    cur[0] = mk(1'b1, 8'h31, 8'h44);
    cur[1] = mk(1'b1, 8'h32, 8'h55);
    drive_m(0, 1'b1, cur[0]);
    drive_m(1, 1'b1, cur[1]);
    owner = 0; last_m = 0; ms = M_NEW;
    run_traffic(0, 200);
    chk("mid_acks", {ack_cnt[0], ack_cnt[1]}, {32'd1, 32'd1});

    // Random mixed traffic.
    for (int i = 0; i < 30; i++) begin
      q0.push_back(rnd_txn());
      q1.push_back(rnd_txn());
    end
    run_traffic(3, 5000);
    chk("rand_acks", {ack_cnt[0], ack_cnt[1]}, {32'd30, 32'd30});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
